// File: rtl/fb_pkg.sv
// Shared constants, types and pixel/word helpers for the framebuffer responder.
package fb_pkg;

  localparam int ADDR_W       = 9;
  localparam int PIX_W        = 4;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  typedef logic [PIX_W-1:0]        pixel_t;
  typedef logic [WORD_W-1:0]       word_t;
  typedef logic [ADDR_W:0]         fb_addr_t;
  typedef logic [PIX_PER_WORD-1:0] mask_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam fb_addr_t FB_ADDR_ZERO = {(ADDR_W+1){1'b0}};
  localparam fb_addr_t FB_ADDR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam fb_addr_t FB_ADDR_LAST = {(ADDR_W+1){1'b1}};
  localparam word_t    WORD_ZERO    = {WORD_W{1'b0}};
  localparam mask_t    MASK_ZERO    = {PIX_PER_WORD{1'b0}};
  localparam mask_t    MASK_ALL     = {PIX_PER_WORD{1'b1}};
  localparam pixel_t   PIXEL_ZERO   = {PIX_W{1'b0}};

  function automatic word_t replicate_pixel(input pixel_t p);
    return {PIX_PER_WORD{p}};
  endfunction

  function automatic mask_t pix_mask(input logic [2:0] sel);
    return {{(PIX_PER_WORD-1){1'b0}}, 1'b1} << sel;
  endfunction

  function automatic pixel_t select_pixel(input word_t w, input logic [2:0] sel);
    return w[int'(sel)*PIX_W +: PIX_W];
  endfunction

  function automatic word_t merge_word(input word_t old_w, input word_t new_w, input mask_t m);
    word_t r;
    r = old_w;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      r[i*PIX_W +: PIX_W] = m[i] ? new_w[i*PIX_W +: PIX_W] : old_w[i*PIX_W +: PIX_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/fb_word_hold.sv
// One-word display hold register with address tag, write-through merge and
// the two-stage pixel return pipeline.
module fb_word_hold
  import fb_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rd_req,
  input  logic                    rd_fetch,
  input  logic [ADDR_W:0]         rd_addr,
  input  logic [2:0]              rd_sel,
  input  logic [WORD_W-1:0]       sram_rdata,
  input  logic                    wr_en,
  input  logic [ADDR_W:0]         wr_addr,
  input  logic [WORD_W-1:0]       wr_data,
  input  logic [PIX_PER_WORD-1:0] wr_mask,
  output logic [PIX_W-1:0]        rd_pixel,
  output logic                    rd_valid
);

  logic       s1_valid_r;
  logic       s1_fetch_r;
  fb_addr_t   s1_tag_r;
  logic [2:0] s1_sel_r;
  word_t      hold_r;
  fb_addr_t   tag_r;
  logic       tag_valid_r;
  pixel_t     rd_pixel_r;
  logic       rd_valid_r;

  word_t      base_word_s;
  fb_addr_t   base_tag_s;
  logic       base_valid_s;
  word_t      hold_next_s;

  // Hold contents at the end of this cycle: fresh capture (if any) with this cycle's write merged on top.
  always_comb begin
    base_word_s  = s1_fetch_r ? sram_rdata : hold_r;
    base_tag_s   = s1_fetch_r ? s1_tag_r   : tag_r;
    base_valid_s = s1_fetch_r | tag_valid_r;
    hold_next_s  = base_word_s;
    if (wr_en && base_valid_s && (wr_addr == base_tag_s)) begin
      hold_next_s = merge_word(base_word_s, wr_data, wr_mask);
    end else begin
      hold_next_s = base_word_s;
    end
  end

  // Read pipeline, hold register and tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_fetch_r  <= 1'b0;
      s1_tag_r    <= FB_ADDR_ZERO;
      s1_sel_r    <= 3'd0;
      hold_r      <= WORD_ZERO;
      tag_r       <= FB_ADDR_ZERO;
      tag_valid_r <= 1'b0;
      rd_pixel_r  <= PIXEL_ZERO;
      rd_valid_r  <= 1'b0;
    end else begin
      s1_valid_r  <= rd_req;
      s1_fetch_r  <= rd_req & rd_fetch;
      s1_tag_r    <= rd_addr;
      s1_sel_r    <= rd_sel;
      hold_r      <= hold_next_s;
      tag_r       <= base_tag_s;
      tag_valid_r <= base_valid_s;
      rd_valid_r  <= s1_valid_r;
      if (s1_valid_r) begin
        rd_pixel_r <= select_pixel(hold_next_s, s1_sel_r);
      end else begin
        rd_pixel_r <= rd_pixel_r;
      end
    end
  end

  assign rd_pixel = rd_pixel_r;
  assign rd_valid = rd_valid_r;

endmodule

// File: rtl/fb_responder.sv
// Framebuffer memory responder: display fetches, engine pixel writes and the
// whole-buffer fill share one synchronous SRAM port, display fetches first.
module fb_responder
  import fb_pkg::*;
(
  input  logic                    clk_25,
  input  logic                    rst_n,
  input  logic                    mem_read,
  input  logic                    mem_row,
  input  logic                    bank,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [2:0]              pix_sel,
  output logic [PIX_W-1:0]        rd_pixel,
  output logic                    rd_valid,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic                    wr_bank,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [2:0]              wr_pix_sel,
  input  logic [PIX_W-1:0]        wr_pixel,
  input  logic                    fill_req,
  input  logic [PIX_W-1:0]        fill_color,
  output logic                    busy,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_W:0]         sram_addr,
  output logic [WORD_W-1:0]       sram_wdata,
  output logic [PIX_PER_WORD-1:0] sram_wmask,
  input  logic [WORD_W-1:0]       sram_rdata
);

  fill_state_e state_r, state_next_s;
  fb_addr_t    fill_cnt_r, fill_cnt_next_s;
  pixel_t      fill_color_r, fill_color_next_s;

  logic        disp_fetch_s;
  logic        wr_ready_s;
  logic        eng_wr_s;
  logic        fill_wr_s;
  logic        sram_en_s;
  logic        sram_we_s;
  fb_addr_t    sram_addr_s;
  word_t       sram_wdata_s;
  mask_t       sram_wmask_s;

  // Fill FSM state, word counter and latched colour.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FILL;
      fill_cnt_r   <= FB_ADDR_ZERO;
      fill_color_r <= PIXEL_ZERO;
    end else begin
      state_r      <= state_next_s;
      fill_cnt_r   <= fill_cnt_next_s;
      fill_color_r <= fill_color_next_s;
    end
  end

  // Port arbitration, next-state logic and SRAM strobes.
  always_comb begin
    disp_fetch_s      = mem_read & mem_row;
    state_next_s      = state_r;
    fill_cnt_next_s   = fill_cnt_r;
    fill_color_next_s = fill_color_r;
    wr_ready_s        = 1'b0;
    eng_wr_s          = 1'b0;
    fill_wr_s         = 1'b0;

    case (state_r)
      IDLE: begin
        wr_ready_s = ~disp_fetch_s;
        eng_wr_s   = wr_valid & ~disp_fetch_s;
      end
      FILL: begin
        fill_wr_s = ~disp_fetch_s;
        if (fill_wr_s) begin
          fill_cnt_next_s = fill_cnt_r + FB_ADDR_ONE;
          state_next_s    = (fill_cnt_r == FB_ADDR_LAST) ? IDLE : FILL;
        end else begin
          fill_cnt_next_s = fill_cnt_r;
          state_next_s    = FILL;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    // A fill request always (re)starts from word 0, even mid-fill.
    if (fill_req) begin
      state_next_s      = FILL;
      fill_cnt_next_s   = FB_ADDR_ZERO;
      fill_color_next_s = fill_color;
    end else begin
      fill_color_next_s = fill_color_r;
    end

    sram_en_s    = 1'b0;
    sram_we_s    = 1'b0;
    sram_addr_s  = FB_ADDR_ZERO;
    sram_wdata_s = WORD_ZERO;
    sram_wmask_s = MASK_ZERO;
    if (disp_fetch_s) begin
      sram_en_s   = 1'b1;
      sram_addr_s = {bank, addr};
    end else if (eng_wr_s) begin
      sram_en_s    = 1'b1;
      sram_we_s    = 1'b1;
      sram_addr_s  = {wr_bank, wr_addr};
      sram_wdata_s = replicate_pixel(wr_pixel);
      sram_wmask_s = pix_mask(wr_pix_sel);
    end else if (fill_wr_s) begin
      sram_en_s    = 1'b1;
      sram_we_s    = 1'b1;
      sram_addr_s  = fill_cnt_r;
      sram_wdata_s = replicate_pixel(fill_color_r);
      sram_wmask_s = MASK_ALL;
    end else begin
      sram_en_s = 1'b0;
    end
  end

  fb_word_hold u_hold (
    .clk        (clk_25),
    .rst_n      (rst_n),
    .rd_req     (mem_read),
    .rd_fetch   (mem_row),
    .rd_addr    ({bank, addr}),
    .rd_sel     (pix_sel),
    .sram_rdata (sram_rdata),
    .wr_en      (sram_en_s & sram_we_s),
    .wr_addr    (sram_addr_s),
    .wr_data    (sram_wdata_s),
    .wr_mask    (sram_wmask_s),
    .rd_pixel   (rd_pixel),
    .rd_valid   (rd_valid)
  );

  // The port strobes are combinational, so they are forced quiet while reset is held.
  assign busy       = (state_r == FILL);
  assign wr_ready   = rst_n & wr_ready_s;
  assign sram_en    = rst_n & sram_en_s;
  assign sram_we    = rst_n & sram_we_s;
  assign sram_addr  = rst_n ? sram_addr_s  : FB_ADDR_ZERO;
  assign sram_wdata = rst_n ? sram_wdata_s : WORD_ZERO;
  assign sram_wmask = rst_n ? sram_wmask_s : MASK_ZERO;

endmodule

// File: tb/tb_fb_responder.sv
// Self-checking bench for fb_responder: SRAM model, framebuffer-level reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fb_responder;
  import fb_pkg::*;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_row, bank;
  logic [8:0]  addr;
  logic [2:0]  pix_sel;
  logic [3:0]  rd_pixel;
  logic        rd_valid;
  logic        wr_valid, wr_ready, wr_bank;
  logic [8:0]  wr_addr;
  logic [2:0]  wr_pix_sel;
  logic [3:0]  wr_pixel;
  logic        fill_req;
  logic [3:0]  fill_color;
  logic        busy, sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [7:0]  sram_wmask;
  logic [31:0] sram_rdata;

  always #5 clk_25 = ~clk_25;

  fb_responder dut (
    .clk_25(clk_25), .rst_n(rst_n), .mem_read(mem_read), .mem_row(mem_row),
    .bank(bank), .addr(addr), .pix_sel(pix_sel), .rd_pixel(rd_pixel),
    .rd_valid(rd_valid), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_pix_sel(wr_pix_sel),
    .wr_pixel(wr_pixel), .fill_req(fill_req), .fill_color(fill_color),
    .busy(busy), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] apply_mask(logic [31:0] old_w, logic [31:0] new_w, logic [7:0] m);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[i*4 +: 4] = m[i] ? new_w[i*4 +: 4] : old_w[i*4 +: 4];
    return r;
  endfunction

  // SRAM: 1024 x 32, one-cycle read latency, per-nibble write mask; bench preload port.
  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_addr;
  logic [31:0] pl_data;
  always @(posedge clk_25) begin
    if (sram_en && !sram_we) sram_rdata <= mem[sram_addr];
    if (sram_en && sram_we) mem[sram_addr] <= apply_mask(mem[sram_addr], sram_wdata, sram_wmask);
    else if (pl_en) mem[pl_addr] <= pl_data;
  end

  // Reference model: reads return the framebuffer word (fetched or last-fetched)
  // as it stands two cycles later; fill walks words 0..1023 on free port cycles.
  typedef struct { int due; logic fetch; logic [9:0] a; logic [2:0] sel; } rd_t;
  initial begin
    rd_t         rq[$];
    rd_t         e;
    int          cyc;
    logic        m_fill, m_tv;
    logic [9:0]  m_idx, m_tag;
    logic [3:0]  m_color;
    logic [31:0] w;
    cyc = 0; m_fill = 1'b1; m_tv = 1'b0; m_idx = 10'd0; m_tag = 10'd0; m_color = 4'd0;
    forever begin
      @(negedge clk_25);
      if (!rst_n) begin
        chk("rst_rd_valid", rd_valid, 0);   chk("rst_rd_pixel", rd_pixel, 0);
        chk("rst_wr_ready", wr_ready, 0);   chk("rst_busy", busy, 1);
        chk("rst_sram_en", sram_en, 0);     chk("rst_sram_we", sram_we, 0);
        chk("rst_sram_addr", sram_addr, 0); chk("rst_sram_wdata", sram_wdata, 0);
        chk("rst_sram_wmask", sram_wmask, 0);
        rq.delete();
        m_fill = 1'b1; m_idx = 10'd0; m_color = 4'd0; m_tv = 1'b0; m_tag = 10'd0;
      end else begin
        chk("busy", busy, m_fill);
        if (rq.size() > 0 && rq[0].due == cyc) begin
          e = rq.pop_front();
          if (e.fetch) begin m_tv = 1'b1; m_tag = e.a; end
          w = m_tv ? mem[m_tag] : 32'h0;
          chk("rd_valid", rd_valid, 1);
          chk("rd_pixel", rd_pixel, w[e.sel*4 +: 4]);
        end else begin
          chk("rd_valid_idle", rd_valid, 0);
        end
        if (mem_read && mem_row) begin
          chk("fetch_wr_ready", wr_ready, 0); chk("fetch_en", sram_en, 1);
          chk("fetch_we", sram_we, 0);        chk("fetch_addr", sram_addr, {bank, addr});
        end else if (m_fill) begin
          chk("fill_wr_ready", wr_ready, 0);  chk("fill_en", sram_en, 1);
          chk("fill_we", sram_we, 1);         chk("fill_addr", sram_addr, m_idx);
          chk("fill_wdata", sram_wdata, {8{m_color}}); chk("fill_wmask", sram_wmask, 8'hFF);
          if (m_idx == 10'd1023) m_fill = 1'b0;
          m_idx = m_idx + 10'd1;
        end else begin
          chk("idle_wr_ready", wr_ready, 1);  chk("idle_en", sram_en, wr_valid);
          if (wr_valid) begin
            chk("eng_we", sram_we, 1);        chk("eng_addr", sram_addr, {wr_bank, wr_addr});
            chk("eng_wdata", sram_wdata, {8{wr_pixel}});
            chk("eng_wmask", sram_wmask, 8'd1 << wr_pix_sel);
          end
        end
        if (mem_read) rq.push_back('{cyc + 2, mem_row, {bank, addr}, pix_sel});
        if (fill_req) begin m_fill = 1'b1; m_idx = 10'd0; m_color = fill_color; end
      end
      cyc++;
    end
  end

  task automatic step();
    @(posedge clk_25);
    #1;
  endtask

  initial begin
    int busy_cnt, wr0_cnt, guard;
    logic [9:0] t;
    rst_n = 1'b0; mem_read = 1'b0; mem_row = 1'b0; bank = 1'b0; addr = 9'd0; pix_sel = 3'd0;
    wr_valid = 1'b0; wr_bank = 1'b0; wr_addr = 9'd0; wr_pix_sel = 3'd0; wr_pixel = 4'd0;
    fill_req = 1'b0; fill_color = 4'd0; pl_addr = 10'd0; pl_data = 32'd0;
    repeat (3) step();

    // Power-up clear: 1024 busy cycles, one zero word write per cycle.
    rst_n = 1'b1; #1;
    busy_cnt = 0; wr0_cnt = 0; guard = 0;
    while (busy && guard < 1100) begin
      busy_cnt++;
      if (sram_en && sram_we && sram_wmask == 8'hFF && sram_wdata == 32'h0) wr0_cnt++;
      step(); guard++;
    end
    chk("init_busy_cycles", busy_cnt, 1024);
    chk("init_zero_writes", wr0_cnt, 1024);
    chk("init_done_busy", busy, 0);
    chk("init_done_wr_ready", wr_ready, 1);

    // Fetch then hold-register read.
    pl_en = 1'b1; pl_addr = 10'd5; pl_data = 32'h76543210; step(); pl_en = 1'b0;
    mem_read = 1'b1; mem_row = 1'b1; bank = 1'b0; addr = 9'd5; pix_sel = 3'd3;
    step(); mem_row = 1'b0; pix_sel = 3'd7;
    step(); mem_read = 1'b0;
    chk("read_n2_valid", rd_valid, 1); chk("read_n2_pixel", rd_pixel, 4'h3);
    step();
    chk("read_n3_valid", rd_valid, 1); chk("read_n3_pixel", rd_pixel, 4'h7);

    // Write colliding with a fetch waits one cycle.
    mem_read = 1'b1; mem_row = 1'b1; addr = 9'd6; pix_sel = 3'd0;
    wr_valid = 1'b1; wr_bank = 1'b0; wr_addr = 9'd7; wr_pix_sel = 3'd0; wr_pixel = 4'h4;
    #1;
    chk("conflict_wr_ready", wr_ready, 0); chk("conflict_we", sram_we, 0);
    chk("conflict_addr", sram_addr, 10'd6);
    step(); mem_read = 1'b0; #1;
    chk("deferred_wr_ready", wr_ready, 1); chk("deferred_we", sram_we, 1);
    chk("deferred_addr", sram_addr, 10'd7); chk("deferred_wmask", sram_wmask, 8'h01);
    chk("deferred_wdata", sram_wdata, 32'h44444444);
    step(); wr_valid = 1'b0;

    // Write landing in the capture cycle of a fetch is merged into the hold word.
    mem_read = 1'b1; mem_row = 1'b1; addr = 9'd5; pix_sel = 3'd0;
    step(); mem_read = 1'b0; wr_valid = 1'b1; wr_addr = 9'd5; wr_pix_sel = 3'd2; wr_pixel = 4'hA;
    step(); wr_valid = 1'b0;
    step(); mem_read = 1'b1; mem_row = 1'b0; pix_sel = 3'd2;
    step(); pix_sel = 3'd1;
    step(); mem_read = 1'b0;
    chk("merge_pix2", rd_pixel, 4'hA);
    step();
    chk("merge_pix1", rd_pixel, 4'h1);

    // Fill 0x9 while every other cycle is a display fetch.
    fill_req = 1'b1; fill_color = 4'h9; step(); fill_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 2100; k++) begin
      t = 10'(k * 37);
      mem_read = (k % 2 == 0); mem_row = 1'b1; bank = t[9]; addr = t[8:0]; pix_sel = 3'(k);
      if (!busy) break;
      busy_cnt++;
      step();
    end
    mem_read = 1'b0;
    chk("fill9_busy_cycles", busy_cnt, 2048);
    step(); step();
    mem_read = 1'b1; mem_row = 1'b1; bank = 1'b1; addr = 9'd300; pix_sel = 3'd5;
    step(); mem_read = 1'b0;
    step();
    chk("fill9_readback", rd_pixel, 4'h9);

    // Reset in the middle of a fill with reads in flight.
    fill_req = 1'b1; fill_color = 4'h3; step(); fill_req = 1'b0;
    mem_read = 1'b1; mem_row = 1'b0; pix_sel = 3'd4;
    guard = 0;
    while (!(sram_en && sram_we && sram_addr == 10'd300) && guard < 2000) begin step(); guard++; end
    chk("midfill_word", sram_addr, 10'd300);
    rst_n = 1'b0; #1;
    chk("midrst_rd_valid", rd_valid, 0); chk("midrst_busy", busy, 1);
    chk("midrst_sram_en", sram_en, 0);   chk("midrst_wr_ready", wr_ready, 0);
    repeat (3) step();
    mem_read = 1'b0;
    rst_n = 1'b1; #1;
    chk("restart_addr", sram_addr, 10'd0); chk("restart_we", sram_we, 1);
    chk("restart_wdata", sram_wdata, 32'h0);
    guard = 0;
    while (busy && guard < 1100) begin step(); guard++; end
    chk("restart_done", busy, 0);
    mem_read = 1'b1; mem_row = 1'b1; bank = 1'b0; addr = 9'd100; pix_sel = 3'd2;
    step(); mem_read = 1'b0;
    step();
    chk("restart_readback", rd_pixel, 4'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
